multicycle_control_fsm: RTL

- Multicycle control sequencer for the single-issue MIPS datapath.
- Fetches and latches an instruction, decodes it, and drives four datapath selects cycle by cycle:
  - next-PC select
  - writeback-source select
  - ALU port-B select
  - destination-register select
- Also drives the register-write, PC-enable and memory request strobes, and waits on memory hit handshakes.
- Sits between the memory arbiter (ihit/dhit) and the datapath muxes. ALU function decode is handled by a separate block.

---
 rtl/multicycle_control_fsm.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/multicycle_control_fsm.sv
// Multicycle control sequencer for the single-issue MIPS datapath.
// Latches the instruction on ihit, then steps DECODE/EXEC/MEM/WB driving the datapath selects.
module multicycle_control_fsm #(
  parameter int unsigned IW = 32
) (
  input  logic          CLK,
  input  logic          nRST,
  input  logic [IW-1:0] imemload,
  input  logic          ihit,
  input  logic          dhit,
  input  logic          zero,
  output logic          iren,
  output logic          dren,
  output logic          dwen,
  output logic [IW-1:0] instr,
  output logic [1:0]    pc_sel,
  output logic          pc_en,
  output logic [1:0]    mem_to_reg,
  output logic          alu_src,
  output logic          reg_dest,
  output logic          wsel_ra,
  output logic          reg_wen,
  output logic          halt
);

  typedef enum logic [2:0] {
    StFetch,
    StDecode,
    StExec,
    StMem,
    StWb,
    StHalt
  } state_e;

  localparam logic [5:0] OpRtype = 6'h00;
  localparam logic [5:0] OpJ     = 6'h02;
  localparam logic [5:0] OpJal   = 6'h03;
  localparam logic [5:0] OpBeq   = 6'h04;
  localparam logic [5:0] OpBne   = 6'h05;
  localparam logic [5:0] OpAddiu = 6'h09;
  localparam logic [5:0] OpAndi  = 6'h0C;
  localparam logic [5:0] OpOri   = 6'h0D;
  localparam logic [5:0] OpLui   = 6'h0F;
  localparam logic [5:0] OpLw    = 6'h23;
  localparam logic [5:0] OpSw    = 6'h2B;
  localparam logic [5:0] OpHalt  = 6'h3F;
  localparam logic [5:0] FnJr    = 6'h08;

  localparam logic [1:0] PcJmp = 2'd0;
  localparam logic [1:0] PcJr  = 2'd1;
  localparam logic [1:0] PcNxt = 2'd2;
  localparam logic [1:0] PcBr  = 2'd3;

  localparam logic [1:0] WbResult = 2'd0;
  localparam logic [1:0] WbNpc    = 2'd1;
  localparam logic [1:0] WbDload  = 2'd2;
  localparam logic [1:0] WbLui    = 2'd3;

  state_e        state_q, state_d;
  logic [IW-1:0] instr_q, instr_d;
  logic [5:0]    op;
  logic [5:0]    funct;
  logic          br_taken;

  assign op       = instr_q[31:26];
  assign funct    = instr_q[5:0];
  assign br_taken = ((op == OpBeq) && zero) || ((op == OpBne) && !zero);
  assign instr    = instr_q;
  assign halt     = (state_q == StHalt);

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state_q <= StFetch;
      instr_q <= '0;
    end else begin
      state_q <= state_d;
      instr_q <= instr_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    instr_d    = instr_q;
    iren       = 1'b0;
    dren       = 1'b0;
    dwen       = 1'b0;
    pc_en      = 1'b0;
    reg_wen    = 1'b0;
    pc_sel     = PcNxt;
    mem_to_reg = WbResult;
    alu_src    = 1'b0;
    reg_dest   = 1'b0;
    wsel_ra    = 1'b0;

    unique case (state_q)
      StFetch: begin
        iren = 1'b1;
        if (ihit) begin
          instr_d = imemload;
          state_d = StDecode;
        end
      end

      StDecode: state_d = (op == OpHalt) ? StHalt : StExec;

      StExec: begin
        state_d = StFetch;
        case (op)
          OpRtype: begin
            if (funct == FnJr) begin
              pc_sel = PcJr;
              pc_en  = 1'b1;
            end else begin
              state_d = StWb;
            end
          end
          OpAddiu, OpAndi, OpOri: begin
            alu_src = 1'b1;
            state_d = StWb;
          end
          OpLui, OpJal: state_d = StWb;
          OpLw, OpSw: begin
            alu_src = 1'b1;
            state_d = StMem;
          end
          OpBeq, OpBne: begin
            pc_sel = br_taken ? PcBr : PcNxt;
            pc_en  = 1'b1;
          end
          OpJ: begin
            pc_sel = PcJmp;
            pc_en  = 1'b1;
          end
          // Unsupported opcodes retire as a NOP.
          default: pc_en = 1'b1;
        endcase
      end

      StMem: begin
        alu_src = 1'b1;
        if (op == OpLw) begin
          dren = 1'b1;
          if (dhit) begin
            mem_to_reg = WbDload;
            reg_dest   = 1'b1;
            reg_wen    = 1'b1;
            pc_en      = 1'b1;
            state_d    = StFetch;
          end
        end else begin
          dwen = 1'b1;
          if (dhit) begin
            pc_en   = 1'b1;
            state_d = StFetch;
          end
        end
      end

      StWb: begin
        reg_wen = 1'b1;
        pc_en   = 1'b1;
        state_d = StFetch;
        case (op)
          OpAddiu, OpAndi, OpOri: begin
            reg_dest = 1'b1;
            alu_src  = 1'b1;
          end
          OpLui: begin
            mem_to_reg = WbLui;
            reg_dest   = 1'b1;
          end
          // Link write to $31 and the jump retire together.
          OpJal: begin
            mem_to_reg = WbNpc;
            wsel_ra    = 1'b1;
            pc_sel     = PcJmp;
          end
          default: ;
        endcase
      end

      StHalt: state_d = StHalt;

      default: state_d = StFetch;
    endcase

    if (!nRST) begin
      iren    = 1'b0;
      dren    = 1'b0;
      dwen    = 1'b0;
      pc_en   = 1'b0;
      reg_wen = 1'b0;
    end
  end

endmodule
